// File: rtl/weight_updater_pkg.sv
// ---------------------------------------------------------------------------
// weight_updater_pkg
//   Shared definitions for the STDP weight write-back path.
//   - Default geometry (inputs per neuron, neuron count, weight width,
//     weight memory address width).
//   - FSM state encoding used by weight_updater.
//   - Saturation limits for unsigned weights.
// ---------------------------------------------------------------------------
package weight_updater_pkg;

  // Default geometry: 784 inputs x 16 neurons of 24-bit weights
  localparam int DEF_M  = 784;
  localparam int DEF_N  = 16;
  localparam int DEF_W  = 24;
  localparam int DEF_AW = 14;

  // Width of the input-index stream from the count-mux stage
  localparam int IPW = 10;

  // Unsigned weight clamp limits (ceiling shown for the default width)
  localparam int SAT_FLOOR    = 0;
  localparam int DEF_SAT_CEIL = (1 << DEF_W) - 1;

  // Walk controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage : weight_updater_pkg

// File: rtl/weight_updater_if.sv
// ---------------------------------------------------------------------------
// weight_updater_if
//   Synaptic weight memory port: one synchronous read port (data one cycle
//   after the address) and one write port.
//   Ports:
//     raddr  read address
//     rdata  read data, valid one cycle after raddr
//     we     write strobe
//     waddr  write address
//     wdata  write data
//   Modports:
//     master  the updater (drives addresses and write data)
//     slave   the memory  (returns read data)
// ---------------------------------------------------------------------------
interface weight_updater_if #(
  parameter int AW = 14,
  parameter int W  = 24
);

  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;

  modport master (
    output raddr,
    output we,
    output waddr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  raddr,
    input  we,
    input  waddr,
    input  wdata,
    output rdata
  );

endinterface : weight_updater_if

// File: rtl/weight_updater_sat_addsub.sv
// ---------------------------------------------------------------------------
// sat_addsub
//   Combinational unsigned y = clamp(a + p - m, 0, 2^W-1).
//   The arithmetic is done in a signed W+2-bit intermediate, which holds
//   both the largest sum (2*(2^W-1)) and the most negative result (-(2^W-1))
//   without wrap.
//   Ports:
//     a  current weight
//     p  positive delta (potentiation)
//     m  negative delta (depression)
//     y  saturated result
// ---------------------------------------------------------------------------
module sat_addsub #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] p,
  input  logic [W-1:0] m,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] Y_FLOOR = {W{1'b0}};
  localparam logic [W-1:0] Y_CEIL  = {W{1'b1}};

  logic signed [W+1:0] sum_s;

  // Extended add/subtract followed by the two-sided clamp
  always_comb begin
    sum_s = $signed({2'b00, a}) + $signed({2'b00, p}) - $signed({2'b00, m});
    if (sum_s[W+1]) begin
      // negative result
      y = Y_FLOOR;
    end else if (sum_s[W]) begin
      // positive but beyond the unsigned W-bit range
      y = Y_CEIL;
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule : sat_addsub

// File: rtl/weight_updater.sv
// ---------------------------------------------------------------------------
// weight_updater
//   Write-back end of the STDP learning path. When an output neuron wins,
//   the count-mux stage walks input indices 1..M-1 on ip_select and the LUT
//   stage presents the matching deltas two cycles later. This block reads
//   each weight of the winning neuron's row, applies the deltas with
//   saturation, and writes the result back, one write per cycle.
//
//   Ports:
//     clk          clock, rising edge
//     rst          asynchronous active-low reset
//     start_wch    one-hot winner strobe (lowest set bit wins)
//     ip_select    input index from the count-mux stage, 0 = idle
//     del_w_plus   potentiation delta for the index seen two cycles earlier
//     del_w_minus  depression delta, same alignment
//     wmem         weight memory port (master side)
//     busy         high from the cycle after capture until done
//     done         one-cycle pulse together with the final write
//     overrun      one-cycle pulse when a winner arrives during a walk
//
//   Pipeline for an index i presented on ip_select in cycle c:
//     c+1  read address visible, stage-1 valid
//     c+2  read data and deltas valid, stage-2 valid
//     c+3  saturated write visible
// ---------------------------------------------------------------------------
module weight_updater
  import weight_updater_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int AW = DEF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     start_wch,
  input  logic [IPW-1:0]   ip_select,
  input  logic [W-1:0]     del_w_plus,
  input  logic [W-1:0]     del_w_minus,
  weight_updater_if.master wmem,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int              NIW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [IPW-1:0]  LAST_IDX = IPW'(M - 1);
  localparam logic [AW-1:0]   ROW_LEN  = AW'(M);

  // FSM
  state_t state_r;
  state_t state_nx_s;

  // Control strobes decoded from the FSM
  logic capture_s;
  logic issue_s;
  logic finish_s;
  logic overrun_s;

  // Winner index and captured row base address
  logic [NIW-1:0] nidx_s;
  logic [AW-1:0]  base_r;

  // Two-deep valid/index pipe
  logic           v1_r;
  logic [IPW-1:0] idx1_r;
  logic           v2_r;
  logic [IPW-1:0] idx2_r;

  // Saturated new weight for the stage-2 index
  logic [W-1:0] wnew_s;

  // Lowest set bit of the winner strobe; scanning from the top down lets
  // the lowest set bit overwrite any higher one.
  always_comb begin
    nidx_s = {NIW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      if (start_wch[i]) begin
        nidx_s = NIW'(i);
      end else begin
        nidx_s = nidx_s;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state and control strobe decode
  always_comb begin
    state_nx_s = state_r;
    capture_s  = 1'b0;
    issue_s    = 1'b0;
    finish_s   = 1'b0;
    overrun_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_wch != {N{1'b0}}) begin
          capture_s  = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        overrun_s = (start_wch != {N{1'b0}});
        if (ip_select != {IPW{1'b0}}) begin
          issue_s = 1'b1;
          if (ip_select == LAST_IDX) begin
            state_nx_s = ST_DRAIN;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        overrun_s = (start_wch != {N{1'b0}});
        // Final write is the one in stage 2 with nothing left behind it
        if (v2_r && !v1_r) begin
          finish_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Row base capture: base = winner index * row length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_r <= {AW{1'b0}};
    end else if (capture_s) begin
      base_r <= AW'(nidx_s) * ROW_LEN;
    end else begin
      base_r <= base_r;
    end
  end

  // Read address issue and stage-1 of the index pipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wmem.raddr <= {AW{1'b0}};
      v1_r       <= 1'b0;
      idx1_r     <= {IPW{1'b0}};
    end else begin
      v1_r <= issue_s;
      if (issue_s) begin
        wmem.raddr <= base_r + AW'(ip_select);
        idx1_r     <= ip_select;
      end else begin
        wmem.raddr <= wmem.raddr;
        idx1_r     <= idx1_r;
      end
    end
  end

  // Stage-2 of the index pipe, aligned with read data and deltas
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_r   <= 1'b0;
      idx2_r <= {IPW{1'b0}};
    end else begin
      v2_r   <= v1_r;
      idx2_r <= idx1_r;
    end
  end

  sat_addsub #(
    .W(W)
  ) u_sat (
    .a(wmem.rdata),
    .p(del_w_plus),
    .m(del_w_minus),
    .y(wnew_s)
  );

  // Registered write port; done rides on the final write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wmem.we    <= 1'b0;
      wmem.waddr <= {AW{1'b0}};
      wmem.wdata <= {W{1'b0}};
      done       <= 1'b0;
    end else begin
      wmem.we <= v2_r;
      done    <= finish_s;
      if (v2_r) begin
        wmem.waddr <= base_r + AW'(idx2_r);
        wmem.wdata <= wnew_s;
      end else begin
        wmem.waddr <= wmem.waddr;
        wmem.wdata <= wmem.wdata;
      end
    end
  end

  // Status flags: busy spans capture through the done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= overrun_s;
      if (capture_s) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end else begin
        busy <= busy;
      end
    end
  end

endmodule : weight_updater

// File: tb/tb_weight_updater.sv
// ---------------------------------------------------------------------------
// tb_weight_updater
//   Drives winner strobes and index/delta streams the way the count-mux/LUT
//   stage would, backs the DUT with a synchronous weight memory, and checks
//   every write against a reference model (clamped a+p-m per row entry)
//   held in a scoreboard queue popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_weight_updater;

  localparam int M  = 8;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 6;
  localparam int ROWS_WORDS = M * N;

  typedef struct {
    int addr;
    int data;
    bit last;
    int cyc;
  } wr_t;

  logic           clk;
  logic           rst;
  logic [N-1:0]   start_wch;
  logic [9:0]     ip_select;
  logic [W-1:0]   del_w_plus;
  logic [W-1:0]   del_w_minus;
  logic           busy;
  logic           done;
  logic           overrun;

  // bench-side preload port of the memory model
  logic           pl_we;
  logic [AW-1:0]  pl_addr;
  logic [W-1:0]   pl_data;

  logic [W-1:0]   mem [0:(1<<AW)-1];
  int             model_mem [0:ROWS_WORDS-1];

  wr_t sb_q[$];
  int  ovr_q[$];
  int  wdp [1:M-1];
  int  wdm [1:M-1];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc      = 0;

  weight_updater_if #(.AW(AW), .W(W)) wm ();

  weight_updater #(.M(M), .N(N), .W(W), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_wch   (start_wch),
    .ip_select   (ip_select),
    .del_w_plus  (del_w_plus),
    .del_w_minus (del_w_minus),
    .wmem        (wm),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // synchronous weight memory: one-cycle read latency
  always @(posedge clk) begin
    wm.rdata <= mem[wm.raddr];
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (wm.we) mem[wm.waddr] <= wm.wdata;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > (1 << W) - 1) return (1 << W) - 1;
    return v;
  endfunction

  // monitor: pops the scoreboard whenever the DUT writes or flags overrun
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (pl_we) model_mem[int'(pl_addr)] = int'(pl_data);
        if (wm.we) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_write: got addr %0d data %0d, expected no write (cycle %0d)",
                     wm.waddr, wm.wdata, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("waddr", int'(wm.waddr), e.addr);
            chk("wdata", int'(wm.wdata), e.data);
            chk("done_with_write", int'(done), int'(e.last));
            chk("write_cycle", cyc, e.cyc);
            model_mem[e.addr] = e.data;
          end
        end else if (done) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_without_write: got done=1 we=0, expected done only with a write (cycle %0d)", cyc);
        end
        if (done) done_cnt++;
        if (overrun) begin
          if (ovr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_overrun: got overrun=1, expected 0 (cycle %0d)", cyc);
          end else begin
            chk("overrun_cycle", cyc, ovr_q.pop_front());
          end
        end
      end
    end
  end

  task automatic preload(input int a, input int d);
    pl_we   = 1'b1;
    pl_addr = AW'(a);
    pl_data = W'(d);
    @(posedge clk); #1;
    pl_we   = 1'b0;
  endtask

  // One winner walk. ovr_at: cycle offset of an extra winner strobe (0 none);
  // abort_at: cycle offset where reset is asserted (0 none).
  task automatic walk(input logic [N-1:0] st, input int ovr_at, input int abort_at);
    int  c0;
    int  nidx;
    int  base;
    wr_t e;
    nidx = -1;
    for (int b = N - 1; b >= 0; b--) if (st[b]) nidx = b;
    base = nidx * M;
    start_wch = st;
    c0 = cyc;
    for (int i = 1; i <= M - 1; i++) begin
      e.addr = base + i;
      e.data = sat(model_mem[base + i] + wdp[i] - wdm[i]);
      e.last = (i == M - 1);
      e.cyc  = c0 + i + 3;
      sb_q.push_back(e);
    end
    if (ovr_at != 0) ovr_q.push_back(c0 + ovr_at + 1);
    for (int j = 1; j <= M + 3; j++) begin
      @(posedge clk); #1;
      start_wch   = (j == ovr_at) ? N'(1) : '0;
      ip_select   = (j <= M - 1) ? 10'(j) : 10'd0;
      del_w_plus  = (j - 2 >= 1 && j - 2 <= M - 1) ? W'(wdp[j - 2]) : '0;
      del_w_minus = (j - 2 >= 1 && j - 2 <= M - 1) ? W'(wdm[j - 2]) : '0;
      if (j == abort_at) begin
        rst = 1'b0;
        #1;
        chk("we_after_reset", int'(wm.we), 0);
        chk("busy_after_reset", int'(busy), 0);
        sb_q.delete();
        ovr_q.delete();
        start_wch   = '0;
        ip_select   = '0;
        del_w_plus  = '0;
        del_w_minus = '0;
        break;
      end
      chk("busy", int'(busy), (j <= M + 2) ? 1 : 0);
    end
  endtask

  task automatic set_deltas(input int p, input int m);
    for (int i = 1; i <= M - 1; i++) begin
      wdp[i] = p;
      wdm[i] = m;
    end
  endtask

  task automatic fill_row(input int row, input int v);
    for (int i = 0; i < M; i++) preload(row * M + i, v);
  endtask

  initial begin
    int saved_done;
    int row;
    logic [N-1:0] st;
    rst = 1'b0;
    start_wch = '0;
    ip_select = '0;
    del_w_plus = '0;
    del_w_minus = '0;
    pl_we = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_we", int'(wm.we), 0);
    chk("rst_raddr", int'(wm.raddr), 0);
    chk("rst_waddr", int'(wm.waddr), 0);
    chk("rst_wdata", int'(wm.wdata), 0);
    rst = 1'b1;

    for (int a = 0; a < ROWS_WORDS; a++) preload(a, $urandom_range(0, 255));

    // single update: row 2 all 100, +5/-2
    fill_row(2, 100);
    set_deltas(5, 2);
    walk(4'b0100, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("row2_idx0_untouched", int'(mem[16]), 100);
    chk("row2_idx1_written", int'(mem[17]), 103);

    // saturation high and low
    fill_row(1, 250);
    set_deltas(10, 0);
    walk(4'b0010, 0, 0);
    fill_row(3, 3);
    set_deltas(0, 9);
    walk(4'b1000, 0, 0);

    // multi-hot winner picks neuron 1
    for (int i = 1; i <= M - 1; i++) begin
      wdp[i] = $urandom_range(0, 40);
      wdm[i] = $urandom_range(0, 40);
    end
    walk(4'b1010, 0, 0);

    // overrun mid-walk
    walk(4'b0100, 4, 0);

    // randomized walks
    for (int r = 0; r < 6; r++) begin
      st = N'($urandom_range(1, (1 << N) - 1));
      row = 0;
      for (int b = N - 1; b >= 0; b--) if (st[b]) row = b;
      for (int i = 0; i < M; i++) preload(row * M + i, $urandom_range(0, 255));
      for (int i = 1; i <= M - 1; i++) begin
        wdp[i] = $urandom_range(0, 60);
        wdm[i] = $urandom_range(0, 60);
      end
      walk(st, 0, 0);
      @(posedge clk); #1;
    end

    // reset mid-walk, then a normal walk to show recovery
    set_deltas(7, 1);
    saved_done = done_cnt;
    walk(4'b0001, 0, 5);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt, saved_done);
    chk("idle_after_abort_busy", int'(busy), 0);
    set_deltas(3, 4);
    walk(4'b0001, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    chk("sb_empty", sb_q.size(), 0);
    chk("ovr_q_empty", ovr_q.size(), 0);
    for (int a = 0; a < ROWS_WORDS; a++) chk("mem_final", int'(mem[a]), model_mem[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_weight_updater
